// File: rtl/ddsm_pkg.sv
// ddsm_pkg: shared state encoding and width helpers for the DDSM density decoder.
package ddsm_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} ddsm_state_e;
  localparam int C_WIN_LOG2 = 8;
  localparam int C_DATA_WIDTH = 8;
  localparam int C_CNT_W = C_WIN_LOG2 + 1;
  localparam int C_SHIFT = C_WIN_LOG2 - C_DATA_WIDTH;
  function automatic int f_cnt_w(input int win_log2);
    return win_log2 + 1;
  endfunction
  function automatic int f_shift(input int win_log2, input int data_width);
    return win_log2 - data_width;
  endfunction
endpackage

// File: rtl/ddsm_ones_counter.sv
// ddsm_ones_counter: valid-qualified sample/ones counters with a last-sample strobe.
module ddsm_ones_counter
  import ddsm_pkg::*;
#(
  parameter int P_WIN_LOG2 = C_WIN_LOG2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              clr_i,
  input  logic                              en_i,
  input  logic                              valid_i,
  input  logic                              bit_i,
  output logic [f_cnt_w(P_WIN_LOG2)-1:0]    ones_o,
  output logic                              last_o
);
  logic [P_WIN_LOG2-1:0] samp_q, samp_d;
  logic [P_WIN_LOG2:0]   ones_q, ones_d;
  logic                  inc;
  // ones_o includes the current sample so the window total is ready on the last strobe
  always_comb begin
    inc    = en_i && valid_i;
    last_o = inc && (&samp_q);
    ones_o = ones_q + (P_WIN_LOG2 + 1)'(bit_i && inc);
    samp_d = clr_i ? '0 : inc ? samp_q + 1'b1 : samp_q;
    ones_d = (clr_i || last_o) ? '0 : ones_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      samp_q <= '0;
      ones_q <= '0;
    end else begin
      samp_q <= samp_d;
      ones_q <= ones_d;
    end
  end
endmodule

// File: rtl/ddsm_density_decoder.sv
// ddsm_density_decoder: recovers the DDSM fraction from ones over 2^P_WIN_LOG2 valid samples.
// Define DDSM_DEC_CONT_EN for back-to-back windows with a sticky overrun flag.
module ddsm_density_decoder
  import ddsm_pkg::*;
#(
  parameter int P_DATA_WIDTH = C_DATA_WIDTH,
  parameter int P_WIN_LOG2   = C_WIN_LOG2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic                    i_quantize,
  input  logic                    i_quantize_valid,
  output logic [P_DATA_WIDTH-1:0] o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_sat,
  output logic                    o_overrun
);
  localparam int cnt_w = f_cnt_w(P_WIN_LOG2);
  localparam int shift = f_shift(P_WIN_LOG2, P_DATA_WIDTH);
  if (P_WIN_LOG2 < P_DATA_WIDTH) begin : g_bad_win
    $error("P_WIN_LOG2 must be >= P_DATA_WIDTH");
  end
  ddsm_state_e             state_q, state_d;
  logic [P_DATA_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d, sat_q, sat_d;
  logic [cnt_w-1:0]        ones;
  logic [P_WIN_LOG2-1:0]   scaled;
  logic                    last, sat;
  ddsm_ones_counter #(.P_WIN_LOG2(P_WIN_LOG2)) u_cnt (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (state_q == S_IDLE),
    .en_i   (state_q == S_ACCUM),
    .valid_i(i_quantize_valid),
    .bit_i  (i_quantize),
    .ones_o (ones),
    .last_o (last)
  );
`ifdef DDSM_DEC_CONT_EN
  logic ovr_q, ovr_d;
`endif
  // a completing window always wins over a same-cycle transfer
  always_comb begin
    sat     = ones[P_WIN_LOG2];
    scaled  = ones[P_WIN_LOG2-1:0] >> shift;
    data_d  = last ? (sat ? '1 : scaled[P_DATA_WIDTH-1:0]) : data_q;
    sat_d   = last ? sat : sat_q;
    valid_d = last || (valid_q && !i_ready);
`ifdef DDSM_DEC_CONT_EN
    state_d = (state_q == S_IDLE && i_start) ? S_ACCUM : state_q;
    ovr_d   = ovr_q || (last && valid_q && !i_ready);
`else
    state_d = (state_q == S_IDLE && i_start)             ? S_ACCUM :
              (state_q == S_ACCUM && last)               ? S_DONE  :
              (state_q == S_DONE && valid_q && i_ready)  ? S_IDLE  : state_q;
`endif
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end
`ifdef DDSM_DEC_CONT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) ovr_q <= 1'b0;
    else ovr_q <= ovr_d;
  end
  assign o_overrun = ovr_q;
`else
  assign o_overrun = 1'b0;
`endif
  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;
  assign o_busy  = state_q == S_ACCUM;
endmodule

// File: tb/tb_ddsm_density_decoder.sv
// tb_ddsm_density_decoder: scoreboard bench; window stimulus pushes expected {sat,data}, outputs are popped and compared.
module tb_ddsm_density_decoder;
  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_start = 1'b0, i_quantize = 1'b0, i_quantize_valid = 1'b0, i_ready = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_busy, o_sat, o_overrun;
  logic [8:0] exp_q[$];
  int         n_chk = 0, n_pass = 0;

  ddsm_density_decoder dut (
    .i_clk           (clk),
    .i_rst           (i_rst),
    .i_start         (i_start),
    .i_quantize      (i_quantize),
    .i_quantize_valid(i_quantize_valid),
    .o_data          (o_data),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_busy          (o_busy),
    .o_sat           (o_sat),
    .o_overrun       (o_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, o_valid, 0);
    check({tag, "_data"}, o_data, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_sat"}, o_sat, 0);
    check({tag, "_ovr"}, o_overrun, 0);
  endtask

  // kinds: 0 = 1,0,0,0  1 = all ones  2 = all zeros  3 = modulator 0xB3 seed 0  4 = random
  task automatic run_window(input int kind, input bit do_start, input bit gaps, input int abort_at, input bit ready_last);
    int         n = 0, ones = 0, cyc = 0;
    logic [7:0] acc = 8'h00;
    logic [8:0] s;
    logic       q;
    if (do_start) begin
      i_start = 1'b1;
      step();
      i_start = 1'b0;
    end
    while (n < 256) begin
      if (abort_at != 0 && n == abort_at) begin
        i_quantize_valid = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        check_reset("mid_rst");
        return;
      end
      i_start = gaps && cyc == 101;
      if (gaps && cyc[0]) begin
        i_quantize_valid = 1'b0;
        i_quantize = 1'($urandom);
      end else begin
        s = {1'b0, acc} + 9'h0B3;
        q = kind == 0 ? (n % 4 == 0) : kind == 1 ? 1'b1 : kind == 2 ? 1'b0 : kind == 3 ? s[8] : 1'($urandom);
        acc = s[7:0];
        ones += int'(q);
        n++;
        i_quantize_valid = 1'b1;
        i_quantize = q;
      end
      i_ready = ready_last && n == 256;
      step();
      cyc++;
      if (gaps && cyc == 102) check("busy_after_2nd_start", o_busy, 1);
    end
    i_quantize_valid = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b0;
    exp_q.push_back(ones == 256 ? 9'h1FF : {1'b0, 8'(ones)});
  endtask

  task automatic check_out(input int stall, input bit exp_busy);
    int         w = 0;
    logic [8:0] e;
    logic [7:0] d0;
    bit         stable = 1'b1;
    while (!o_valid && w < 10) begin
      step();
      w++;
    end
    check("valid_seen", o_valid, 1);
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("data", o_data, e[7:0]);
    check("sat", o_sat, e[8]);
    check("busy_at_result", o_busy, exp_busy);
    d0 = o_data;
    repeat (stall) begin
      step();
      stable &= (o_data == d0) && o_valid;
    end
    if (stall > 0) check("stall_stable", stable, 1);
    i_ready = 1'b1;
    i_start = 1'b1;
    step();
    i_ready = 1'b0;
    i_start = 1'b0;
    check("valid_clr", o_valid, 0);
    check("busy_after_xfer", o_busy, exp_busy);
  endtask

  initial begin
    step();
    step();
    i_rst = 1'b0;
    check_reset("reset");
`ifdef DDSM_DEC_CONT_EN
    run_window(1, 1'b1, 1'b0, 0, 1'b0);
    run_window(0, 1'b0, 1'b0, 0, 1'b0);
    check("ovr_set", o_overrun, 1);
    check("ovr_valid", o_valid, 1);
    void'(exp_q.pop_front());
    check_out(0, 1'b1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check_reset("cont_rst");
    run_window(2, 1'b1, 1'b0, 0, 1'b0);
    run_window(0, 1'b0, 1'b0, 0, 1'b1);
    check("same_cycle_valid", o_valid, 1);
    check("same_cycle_no_ovr", o_overrun, 0);
    void'(exp_q.pop_front());
    check_out(0, 1'b1);
`else
    run_window(0, 1'b1, 1'b0, 0, 1'b0);
    check("pattern_0x40", o_data, 8'h40);
    check_out(0, 1'b0);
    run_window(3, 1'b1, 1'b0, 0, 1'b0);
    check("efm_b3_range", (o_data >= 8'hB2) && (o_data <= 8'hB4), 1);
    check_out(0, 1'b0);
    run_window(1, 1'b1, 1'b0, 0, 1'b0);
    check_out(3, 1'b0);
    run_window(2, 1'b1, 1'b0, 0, 1'b0);
    check_out(0, 1'b0);
    run_window(0, 1'b1, 1'b1, 0, 1'b0);
    check_out(20, 1'b0);
    run_window(4, 1'b1, 1'b0, 100, 1'b0);
    run_window(4, 1'b1, 1'b0, 0, 1'b0);
    check_out(0, 1'b0);
    check("no_overrun", o_overrun, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
